// File: rtl/barrel_pkg.sv
// Shared definitions for barrel_shift_seq: FSM state encoding, op codes and fill-bit helper.
// The BARREL_ROTATE_EN build option is consumed by barrel_stage and barrel_shift_seq.
package barrel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic [1:0] OP_LOGIC = 2'b00;
  localparam logic [1:0] OP_ARITH = 2'b01;
  localparam logic [1:0] OP_ROT   = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  // Only arithmetic right shifts replicate the sign; every other case fills with zero.
  function automatic logic fill_bit(input logic [1:0] op, input logic dir, input logic msb);
    logic f;
    f = 1'b0;
    if ((op == OP_ARITH) && dir) begin
      f = msb;
    end else begin
      f = 1'b0;
    end
    return f;
  endfunction

endpackage

// File: rtl/barrel_stage.sv
// One combinational log stage of the barrel shifter: per-bit 4:1 mux of hold/left/right/rotate.
// With BARREL_ROTATE_EN undefined the rotate leg collapses onto the plain shift legs.
module barrel_stage #(
  parameter int WIDTH = 8,
  parameter int AMT   = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic             enable,
  input  logic             dir,
  input  logic             fill,
  input  logic             rot,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] left_s;
  logic [WIDTH-1:0] right_s;
  logic [WIDTH-1:0] rotd_s;
  logic [1:0]       sel_s;

  assign left_s  = {data[WIDTH-AMT-1:0], {AMT{1'b0}}};
  assign right_s = {{AMT{fill}}, data[WIDTH-1:AMT]};

`ifdef BARREL_ROTATE_EN
  assign rotd_s = dir ? {data[AMT-1:0], data[WIDTH-1:AMT]}
                      : {data[WIDTH-AMT-1:0], data[WIDTH-1:WIDTH-AMT]};
`else
  assign rotd_s = dir ? right_s : left_s;
`endif

  // Mux select: 00 hold, 01 left, 10 right, 11 rotate.
  always_comb begin
    sel_s = 2'b00;
    if (!enable) begin
      sel_s = 2'b00;
    end else if (rot) begin
      sel_s = 2'b11;
    end else if (dir) begin
      sel_s = 2'b10;
    end else begin
      sel_s = 2'b01;
    end
  end

  // Per-bit 4:1 selection.
  always_comb begin
    result = data;
    for (int i = 0; i < WIDTH; i++) begin
      case (sel_s)
        2'b00:   result[i] = data[i];
        2'b01:   result[i] = left_s[i];
        2'b10:   result[i] = right_s[i];
        2'b11:   result[i] = rotd_s[i];
        default: result[i] = data[i];
      endcase
    end
  end

endmodule

// File: rtl/barrel_shift_seq.sv
// Sequential barrel shifter applying one log stage per clock between valid/ready handshakes.
// Build option BARREL_ROTATE_EN enables op 10 as rotate; otherwise op 10 is a logical shift.
module barrel_shift_seq
  import barrel_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic             in_dir,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int CNTW = $clog2(SHW);

  state_t           state_r;
  state_t           state_nx_s;
  logic [WIDTH-1:0] work_r;
  logic [WIDTH-1:0] stage_sel_s;
  logic [WIDTH-1:0] out_data_r;
  logic [WIDTH-1:0] stage_out_s [SHW];
  logic [SHW-1:0]   shamt_r;
  logic [CNTW-1:0]  cnt_r;
  logic             dir_r;
  logic             fill_r;
  logic             rot_r;
  logic             out_valid_r;
  logic             in_ready_s;
  logic             busy_s;
  logic             last_s;
  logic             accept_s;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    barrel_stage #(.WIDTH(WIDTH), .AMT(1 << k)) u_stage (
      .data   (work_r),
      .enable (shamt_r[k]),
      .dir    (dir_r),
      .fill   (fill_r),
      .rot    (rot_r),
      .result (stage_out_s[k])
    );
  end

  assign stage_sel_s = stage_out_s[cnt_r];
  assign last_s      = (state_r == SHIFT) && (cnt_r == CNTW'(SHW - 1));
  assign accept_s    = in_valid && in_ready_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE:    state_nx_s = in_valid ? SHIFT : IDLE;
      SHIFT:   state_nx_s = last_s ? DONE : SHIFT;
      DONE:    state_nx_s = out_ready ? IDLE : DONE;
      default: state_nx_s = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    in_ready_s = 1'b0;
    busy_s     = 1'b1;
    case (state_r)
      IDLE: begin
        in_ready_s = 1'b1;
        busy_s     = 1'b0;
      end
      SHIFT, DONE: begin
        in_ready_s = 1'b0;
        busy_s     = 1'b1;
      end
      default: begin
        in_ready_s = 1'b0;
        busy_s     = 1'b1;
      end
    endcase
  end

  // Operand capture and per-cycle stage application.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_r  <= {WIDTH{1'b0}};
      shamt_r <= {SHW{1'b0}};
      dir_r   <= 1'b0;
      fill_r  <= 1'b0;
      rot_r   <= 1'b0;
      cnt_r   <= {CNTW{1'b0}};
    end else if (accept_s) begin
      work_r  <= in_data;
      shamt_r <= in_shamt;
      dir_r   <= in_dir;
      fill_r  <= fill_bit(in_op, in_dir, in_data[WIDTH-1]);
`ifdef BARREL_ROTATE_EN
      rot_r   <= (in_op == OP_ROT);
`else
      rot_r   <= 1'b0;
`endif
      cnt_r   <= {CNTW{1'b0}};
    end else if (state_r == SHIFT) begin
      work_r <= stage_sel_s;
      cnt_r  <= last_s ? {CNTW{1'b0}} : cnt_r + CNTW'(1);
    end
  end

  // Result register: loaded with the final stage, held until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
    end else if (last_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= stage_sel_s;
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign in_ready  = in_ready_s;
  assign busy      = busy_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

endmodule

// File: tb/tb_barrel_shift_seq.sv
// Scoreboard bench for barrel_shift_seq: directed and random operands against an arithmetic model.
// Honours BARREL_ROTATE_EN the same way as the design build.
module tb_barrel_shift_seq;

  localparam int W   = 8;
  localparam int SHW = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_data = '0;
  logic [SHW-1:0] in_shamt = '0;
  logic           in_dir = 1'b0;
  logic [1:0]     in_op = 2'b00;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   out_data;
  logic           busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hold_cfg = 0;
  logic [W-1:0] exp_q[$];
  int           acc_q[$];
  logic smp_valid = 1'b0;
  logic smp_ready = 1'b0;
  logic [W-1:0] last_data = '0;

  barrel_shift_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shamt(in_shamt), .in_dir(in_dir), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    smp_valid <= out_valid;
    smp_ready <= out_ready;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: shift by plain integer arithmetic.
  function automatic logic [W-1:0] model(input logic [W-1:0] d, input int s, input bit dr,
                                         input logic [1:0] op);
    int v;
    int sv;
    int r;
    bit rot;
    v   = int'(d);
    rot = 1'b0;
`ifdef BARREL_ROTATE_EN
    rot = (op == 2'b10);
`endif
    if (rot)
      r = dr ? ((v >> s) | (v << (W - s))) : ((v << s) | (v >> (W - s)));
    else if (!dr)
      r = v << s;
    else if (op == 2'b01) begin
      sv = d[W-1] ? v - (1 << W) : v;
      r  = sv >>> s;
    end else
      r = v >> s;
    return r[W-1:0];
  endfunction

  // Monitor: pops the scoreboard on each new result and checks hold/release behaviour.
  always @(negedge clk) begin
    if (rst_n) begin
      if (smp_valid && smp_ready) begin
        check("release_valid", out_valid, 1'b0);
        check("release_ready", in_ready, 1'b1);
      end else if (smp_valid) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_data", out_data, last_data);
        check("hold_in_ready", in_ready, 1'b0);
      end
      if (out_valid && !smp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", out_data, 32'hFFFF_FFFF);
        end else begin
          check("out_data", out_data, exp_q.pop_front());
          check("latency", cyc - acc_q.pop_front(), SHW);
          check("busy_done", busy, 1'b1);
        end
      end
    end
    last_data = out_data;
  end

  // Consumer: random backpressure; hold_cfg cycles of stall once a result appears.
  initial begin
    int hold_left;
    bit armed;
    hold_left = 0;
    armed = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (!armed) begin
          hold_left = hold_cfg;
          armed = 1'b1;
        end
        if (hold_left > 0) begin
          out_ready = 1'b0;
          hold_left--;
        end else begin
          out_ready = 1'b1;
        end
      end else begin
        armed = 1'b0;
        out_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input int s, input bit dr, input logic [1:0] op,
                      input int hold);
    int n;
    @(negedge clk);
    hold_cfg = hold;
    in_data  = d;
    in_shamt = SHW'(s);
    in_dir   = dr;
    in_op    = op;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      check("accept_timeout", n, 0);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      exp_q.push_back(model(d, s, dr, op));
      acc_q.push_back(cyc);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = W'($urandom);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    send(8'b1011_0011, 3, 1'b0, 2'b00, 0);
    send(8'hB4, 2, 1'b1, 2'b01, 0);
    send(8'hB4, 2, 1'b1, 2'b00, 5);
    send(8'h81, 1, 1'b1, 2'b10, 0);
    send(8'h81, 1, 1'b0, 2'b10, 2);
    send(8'h5A, 0, 1'b0, 2'b00, 0);
    send(8'hC3, 0, 1'b1, 2'b10, 0);
    send(8'hB3, 3, 1'b0, 2'b01, 0);
    send(8'hB4, 2, 1'b1, 2'b11, 1);
    send(8'hFF, 7, 1'b1, 2'b01, 0);
    drain();

    // Reset while the second stage is being applied.
    send(8'hF0, 7, 1'b1, 2'b01, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_data", out_data, 8'h00);
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_busy", busy, 1'b0);
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h3C, 2, 1'b0, 2'b00, 0);
    drain();

    for (int t = 0; t < 40; t++) begin
      send(W'($urandom), int'($urandom_range(0, W - 1)), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
